vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer SRAM between two requesters: the VGA scanout path and a CPU bus port.
- Scanout side: prefetches packed pixel words into a small FIFO, then serialises one 8-bit RGB332 pixel per cycle while the timing generator asserts data_enable.
- CPU side: gets the SRAM cycles scanout does not need. Scanout takes priority whenever the FIFO runs low.
- Sits between the VGA timing generator, the CPU bus and the external SRAM.

---
 rtl/vga_fb_pkg.sv | 21 ++
 rtl/vga_fb_arbiter_if.sv | 31 +++
 rtl/fb_word_fifo.sv | 43 ++++
 rtl/vga_fb_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared types and frame geometry for the framebuffer arbiter
package vga_fb_pkg;

   localparam int PIX_PER_WORD = 4;
   localparam int FRAME_WORDS  = 800 * 600 / PIX_PER_WORD;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VID,
      S_CPU_RD,
      S_CPU_WR
   } state_t;

   // RGB332 pixel
   typedef logic [7:0] pixel_t;

   function automatic int frame_words(input int hsize, input int vsize);
      return hsize * vsize / PIX_PER_WORD;
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - CPU bus and SRAM bus seen by the framebuffer arbiter
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 20
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [3:0]        cpu_be;
   logic [31:0]       cpu_rdata;
   logic              cpu_ack;

   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       mem_rdata;

   // master: the arbiter, which serves the CPU and drives the SRAM
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
      output cpu_rdata, cpu_ack, mem_ce, mem_we, mem_addr, mem_wdata, mem_be
   );

   // slave: the CPU and SRAM surrounding the arbiter
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
      input  cpu_rdata, cpu_ack, mem_ce, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/fb_word_fifo.sv
// rtl/fb_word_fifo.sv - 32-bit pixel-word FIFO with flush and level output
module fb_word_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // flush outranks push and pop so a frame restart always leaves the FIFO empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer SRAM shared by VGA scanout and a CPU port
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int HSIZE      = 800,
   parameter int VSIZE      = 600,
   parameter int ADDR_W     = 20,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WM     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  hdata,
   input  logic [WIDTH-1:0]  vdata,
   input  logic              data_enable,
   output pixel_t            pixel,
   output logic              underflow,
   vga_fb_arbiter_if.master  bus
);
   localparam int FRAME_W = frame_words(HSIZE, VSIZE);
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int RSV_W   = LVL_W + 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] fetch_addr;
   logic [1:0]        sub;
   logic [LVL_W-1:0]  level;
   logic [31:0]       head;
   logic [RSV_W-1:0]  reserved;
   logic              frame_restart;
   logic              vid_ok;
   logic              urgent;
   logic              has_space;
   logic              issue_vid;
   logic              issue_cpu;
   logic              push;
   logic              consume;
   logic              fifo_empty;

   assign frame_restart = (vdata == WIDTH'(VSIZE)) && (hdata == '0);
   assign fifo_empty    = (level == '0);
   assign reserved      = RSV_W'(level) + RSV_W'(state == S_VID);
   // no scanout fetch on the restart cycle: its word would land after the flush
   assign vid_ok        = (fetch_addr < ADDR_W'(FRAME_W)) && !frame_restart;
   assign urgent        = reserved < RSV_W'(LOW_WM);
   assign has_space     = reserved < RSV_W'(FIFO_DEPTH);

   always_comb begin
      state_nx  = state;
      issue_vid = 1'b0;
      issue_cpu = 1'b0;
      case (state)
         S_IDLE: begin
            if (vid_ok && urgent)                  issue_vid = 1'b1;
            else if (bus.cpu_req && !bus.cpu_ack)  issue_cpu = 1'b1;
            else if (vid_ok && has_space)          issue_vid = 1'b1;

            if (issue_vid)      state_nx = S_VID;
            else if (issue_cpu) state_nx = bus.cpu_we ? S_CPU_WR : S_CPU_RD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // SRAM strobes are combinational so read data returns in the following state
   always_comb begin
      bus.mem_ce    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      if (!reset) begin
         if (issue_vid) begin
            bus.mem_ce   = 1'b1;
            bus.mem_addr = fetch_addr;
         end else if (issue_cpu) begin
            bus.mem_ce    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : 32'h0;
            bus.mem_be    = bus.cpu_be;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         fetch_addr    <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.cpu_rdata <= '0;
      end else begin
         state       <= state_nx;
         bus.cpu_ack <= (state == S_CPU_RD) || (state == S_CPU_WR);
         if (state == S_CPU_RD) bus.cpu_rdata <= bus.mem_rdata;
         if (frame_restart)        fetch_addr <= '0;
         else if (state == S_VID)  fetch_addr <= fetch_addr + 1'b1;
      end
   end

   assign push    = (state == S_VID) && !frame_restart;
   assign consume = data_enable && !fifo_empty;

   fb_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (consume && (sub == 2'd3)),
      .flush (frame_restart),
      .wdata (bus.mem_rdata),
      .rdata (head),
      .level (level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel     <= '0;
         underflow <= 1'b0;
         sub       <= '0;
      end else begin
         pixel <= consume ? head[{sub, 3'b000} +: 8] : 8'h00;
         if (frame_restart) sub <= '0;
         else if (consume)  sub <= sub + 2'd1;
         if (data_enable && fifo_empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter (reduced 32x8 frame)
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   localparam int WIDTH = 12;
   localparam int HS    = 32;
   localparam int VS    = 8;
   localparam int AW    = 20;
   localparam int HT    = HS + 8;
   localparam int VT    = VS + 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] hdata;
   logic [WIDTH-1:0] vdata;
   logic             data_enable;
   pixel_t           pixel;
   logic             underflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] sram [0:1023];
   logic [31:0] rd_q;
   logic        do_load = 1'b0;
   logic [7:0]  load_off = 8'h00;

   vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

   vga_fb_arbiter #(
      .WIDTH      (WIDTH),
      .HSIZE      (HS),
      .VSIZE      (VS),
      .ADDR_W     (AW),
      .FIFO_DEPTH (16),
      .LOW_WM     (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hdata       (hdata),
      .vdata       (vdata),
      .data_enable (data_enable),
      .pixel       (pixel),
      .underflow   (underflow),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // synchronous SRAM: word n preloads to {4{n[7:0]+load_off}}
   assign bus.mem_rdata = rd_q;
   always @(posedge clk) begin
      if (do_load) begin
         for (int n = 0; n < 1024; n++) sram[n] <= {4{8'(n) + load_off}};
      end else if (bus.mem_ce) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be[b]) sram[bus.mem_addr[9:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end else begin
            rd_q <= sram[bus.mem_addr[9:0]];
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic load_pattern(input logic [7:0] off);
      load_off = off;
      do_load  = 1'b1;
      @(posedge clk);
      #1 do_load = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.cpu_be    = '0;
      hdata         = '0;
      vdata         = '0;
      data_enable   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drive_timing(input int h, input int v);
      hdata       = WIDTH'(h);
      vdata       = WIDTH'(v);
      data_enable = (h < HS) && (v < VS);
   endtask

   task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output int cycles, output logic [31:0] rd,
                           output logic iss_ce, output logic iss_we, output logic [AW-1:0] iss_addr);
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
      bus.cpu_wdata = wd; bus.cpu_be = be;
      #1;
      iss_ce = bus.mem_ce; iss_we = bus.mem_we; iss_addr = bus.mem_addr;
      cycles = -1;
      rd = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.cpu_ack === 1'b1) begin
            cycles = c;
            rd = bus.cpu_rdata;
            break;
         end
      end
      bus.cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (pixel !== 8'h00) begin n_bad++; $display("FAIL reset_pixel got %h want 00", pixel); end
      n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow got %b want 0", underflow); end
      n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_ack got %b want 0", bus.cpu_ack); end
      n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_cpu_rdata got %h want 0", bus.cpu_rdata); end
      n_cmp++; if (bus.mem_ce !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ce got %b want 0", bus.mem_ce); end
      n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin n_bad++; $display("FAIL reset_mem_we_be got %b/%h want 0/0", bus.mem_we, bus.mem_be); end
      n_cmp++; if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr_wdata got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
   endtask

   task automatic test_prefetch();
      int nissue, order_err, late;
      nissue = 0; order_err = 0; late = 0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.mem_ce === 1'b1) begin
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== AW'(nissue)) order_err++;
            nissue++;
            if (c >= 40) late++;
         end
      end
      n_cmp++; if (nissue !== 16) begin n_bad++; $display("FAIL prefetch_count got %0d want 16", nissue); end
      n_cmp++; if (order_err !== 0) begin n_bad++; $display("FAIL prefetch_order got %0d bad issues want 0", order_err); end
      n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL prefetch_idle got %0d late issues want 0", late); end
   endtask

   task automatic test_cpu_access();
      int cyc; logic [31:0] rd; logic ce, we; logic [AW-1:0] ad;
      cpu_xfer(1'b1, AW'(20'h00010), 32'hDEADBEEF, 4'hF, cyc, rd, ce, we, ad);
      n_cmp++; if (ce !== 1'b1 || we !== 1'b1 || ad !== AW'(20'h00010)) begin n_bad++; $display("FAIL cpu_wr_issue got ce=%b we=%b addr=%h want 1/1/00010", ce, we, ad); end
      n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL cpu_wr_ack_latency got %0d want 2", cyc); end
      cpu_xfer(1'b0, AW'(20'h00010), 32'h0, 4'hF, cyc, rd, ce, we, ad);
      n_cmp++; if (cyc !== 2 || we !== 1'b0) begin n_bad++; $display("FAIL cpu_rd_ack got cycles=%0d we=%b want 2/0", cyc, we); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_rd_data got %h want deadbeef", rd); end
      cpu_xfer(1'b1, AW'(20'h00010), 32'h12345678, 4'h3, cyc, rd, ce, we, ad);
      cpu_xfer(1'b0, AW'(20'h00010), 32'h0, 4'hF, cyc, rd, ce, we, ad);
      n_cmp++; if (rd !== 32'hDEAD5678) begin n_bad++; $display("FAIL cpu_partial_write got %h want dead5678", rd); end
   endtask

   task automatic test_priority();
      int first_k, first_we, first_addr, cpu_k, ack_k;
      first_k = -1; first_we = -1; first_addr = -1; cpu_k = -1; ack_k = -1;
      do_reset();
      repeat (4) @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = AW'(20'h00020);
      bus.cpu_wdata = 32'h00000005; bus.cpu_be = 4'hF;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus.mem_ce === 1'b1 && first_k < 0) begin
            first_k = k; first_we = int'(bus.mem_we); first_addr = int'(bus.mem_addr);
         end
         if (bus.mem_ce === 1'b1 && bus.mem_we === 1'b1 && cpu_k < 0) cpu_k = k;
         if (bus.cpu_ack === 1'b1) begin ack_k = k; break; end
      end
      bus.cpu_req = 1'b0;
      n_cmp++; if (first_k !== 1 || first_we !== 0 || first_addr !== 2) begin n_bad++; $display("FAIL priority_first got k=%0d we=%0d addr=%0d want 1/0/2", first_k, first_we, first_addr); end
      n_cmp++; if (cpu_k !== 5) begin n_bad++; $display("FAIL priority_cpu_slot got %0d want 5", cpu_k); end
      n_cmp++; if (ack_k !== 7) begin n_bad++; $display("FAIL priority_ack got %0d want 7", ack_k); end
   endtask

   task automatic test_underflow();
      do_reset();
      @(negedge clk);
      drive_timing(0, 0);
      @(negedge clk);
      n_cmp++; if (pixel !== 8'h00 || underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_set got pixel=%h uf=%b want 00/1", pixel, underflow); end
      drive_timing(0, VS);
      @(negedge clk);
      drive_timing(1, VS);
      @(negedge clk);
      n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky got %b want 1", underflow); end
   endtask

   task automatic test_scanout_frame();
      int h, v, pix_cnt, bad, max_addr;
      pixel_t exp_pix, bad_got, bad_exp;
      h = 0; v = VS; pix_cnt = 0; bad = 0; max_addr = 0; exp_pix = 8'h00;
      bad_got = 8'h00; bad_exp = 8'h00;
      do_reset();
      for (int c = 0; c < VT*HT + 2; c++) begin
         @(negedge clk);
         if (c > 0 && pixel !== exp_pix) begin
            if (bad == 0) begin bad_got = pixel; bad_exp = exp_pix; end
            bad++;
         end
         if (bus.mem_ce === 1'b1 && bus.mem_we === 1'b0 && int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
         drive_timing(h, v);
         if (data_enable) begin
            exp_pix = 8'(pix_cnt / 4);
            pix_cnt++;
         end else begin
            exp_pix = 8'h00;
         end
         h++;
         if (h == HT) begin h = 0; v = (v == VT-1) ? 0 : v + 1; end
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL frame_pixels got %0d wrong (first %h want %h) want 0", bad, bad_got, bad_exp); end
      n_cmp++; if (max_addr !== HS*VS/4 - 1) begin n_bad++; $display("FAIL frame_last_addr got %0d want %0d", max_addr, HS*VS/4 - 1); end
      n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL frame_underflow got %b want 0", underflow); end
   endtask

   task automatic test_restart_capture();
      int h, v, pix_cnt, bad;
      pixel_t exp_pix, bad_got;
      logic ce; logic [AW-1:0] ad;
      pix_cnt = 0; bad = 0; exp_pix = 8'h00; bad_got = 8'h00;
      load_pattern(8'hA0);
      do_reset();
      drive_timing(5, 0);
      repeat (6) @(negedge clk);
      drive_timing(0, VS);
      load_off = 8'h00;
      do_load  = 1'b1;
      @(negedge clk);
      do_load = 1'b0;
      drive_timing(1, VS);
      #1;
      ce = bus.mem_ce; ad = bus.mem_addr;
      n_cmp++; if (ce !== 1'b1 || ad !== '0) begin n_bad++; $display("FAIL restart_next_addr got ce=%b addr=%h want 1/0", ce, ad); end
      h = 2; v = VS;
      for (int c = 0; c < 3*HT - 1; c++) begin
         @(negedge clk);
         if (pixel !== exp_pix) begin
            if (bad == 0) bad_got = pixel;
            bad++;
         end
         drive_timing(h, v);
         if (data_enable) begin
            exp_pix = 8'(pix_cnt / 4);
            pix_cnt++;
         end else begin
            exp_pix = 8'h00;
         end
         h++;
         if (h == HT) begin h = 0; v = (v == VT-1) ? 0 : v + 1; end
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL restart_line0 got %0d wrong (first %h) want 0", bad, bad_got); end
   endtask

   task automatic test_reset_mid_read();
      int cyc; logic [31:0] rd; logic ce, we; logic [AW-1:0] ad; int acks;
      acks = 0;
      do_reset();
      repeat (40) @(negedge clk);
      cpu_xfer(1'b0, AW'(5), 32'h0, 4'hF, cyc, rd, ce, we, ad);
      n_cmp++; if (rd !== 32'h05050505 || cyc !== 2) begin n_bad++; $display("FAIL pre_reset_read got %h cycles=%0d want 05050505/2", rd, cyc); end
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = AW'(6); bus.cpu_be = 4'hF;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (bus.cpu_rdata !== 32'h0 || bus.cpu_ack !== 1'b0) begin n_bad++; $display("FAIL async_reset_cpu got rdata=%h ack=%b want 0/0", bus.cpu_rdata, bus.cpu_ack); end
      n_cmp++; if (bus.mem_ce !== 1'b0 || bus.mem_addr !== '0 || pixel !== 8'h00) begin n_bad++; $display("FAIL async_reset_outputs got ce=%b addr=%h pixel=%h want 0/0/00", bus.mem_ce, bus.mem_addr, pixel); end
      bus.cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.cpu_ack === 1'b1) acks++;
      end
      n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL reset_drops_read got %0d acks want 0", acks); end
   endtask

   initial begin
      test_reset();
      load_pattern(8'h00);
      test_prefetch();
      test_cpu_access();
      test_priority();
      test_underflow();
      load_pattern(8'h00);
      test_scanout_frame();
      test_restart_capture();
      load_pattern(8'h00);
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
